// File: rtl/vga_pattern_sequencer.sv
// Selects the active test pattern for a VGA pattern generator. Manual next/prev
// requests and timed auto-advance take effect only at a frame start (VSync rise).
module vga_pattern_sequencer #(
  parameter int PATTERN_COUNT = 8,
  parameter int INIT_PATTERN  = 0,
  parameter int AUTO_FRAMES   = 60
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_VSync,
  input  logic        i_Next,
  input  logic        i_Prev,
  input  logic        i_Auto_En,
  output logic [3:0]  o_Pattern,
  output logic        o_Pending,
  output logic        o_Frame_Start,
  output logic [15:0] o_Frame_Count
);

  localparam int             CW        = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [3:0]     LAST_PAT  = 4'(PATTERN_COUNT - 1);
  localparam logic [3:0]     INIT_PAT  = 4'(INIT_PATTERN);
  localparam logic [CW-1:0]  AUTO_LAST = CW'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PEND_NEXT = 2'd1,
    PEND_PREV = 2'd2
  } state_t;

  state_t          r_State;
  state_t          w_State_Next;
  logic            r_VSync_d;
  logic            r_Pending;
  logic            r_Frame_Start;
  logic [15:0]     r_Frame_Count;
  logic [3:0]      r_Pattern;
  logic [3:0]      w_Pattern_Next;
  logic [CW-1:0]   r_Auto_Cnt;
  logic [CW-1:0]   w_Auto_Cnt_Next;
  logic            w_Frame_Start;
  logic            w_Next_Only;
  logic            w_Prev_Only;
  logic            w_Step_Up;
  logic            w_Step_Dn;

  assign w_Frame_Start = i_VSync & ~r_VSync_d;
  assign w_Next_Only   = i_Next & ~i_Prev;
  assign w_Prev_Only   = i_Prev & ~i_Next;

  always_comb begin
    w_State_Next    = r_State;
    w_Step_Up       = 1'b0;
    w_Step_Dn       = 1'b0;
    w_Pattern_Next  = r_Pattern;
    w_Auto_Cnt_Next = r_Auto_Cnt;

    if (w_Frame_Start) begin
      case (r_State)
        PEND_NEXT: w_Step_Up = 1'b1;
        PEND_PREV: w_Step_Dn = 1'b1;
        default:   w_Step_Up = i_Auto_En & (r_Auto_Cnt == AUTO_LAST);
      endcase
      // A request arriving on the frame-start cycle waits for the next frame.
      if (w_Next_Only) begin
        w_State_Next = PEND_NEXT;
      end else if (w_Prev_Only) begin
        w_State_Next = PEND_PREV;
      end else begin
        w_State_Next = IDLE;
      end
    end else begin
      case (r_State)
        IDLE: begin
          if (w_Next_Only) begin
            w_State_Next = PEND_NEXT;
          end else if (w_Prev_Only) begin
            w_State_Next = PEND_PREV;
          end else begin
            w_State_Next = IDLE;
          end
        end
        PEND_NEXT: w_State_Next = w_Prev_Only ? IDLE : PEND_NEXT;
        PEND_PREV: w_State_Next = w_Next_Only ? IDLE : PEND_PREV;
        default:   w_State_Next = IDLE;
      endcase
    end

    if (w_Step_Up) begin
      w_Pattern_Next = (r_Pattern == LAST_PAT) ? 4'd0 : r_Pattern + 4'd1;
    end else if (w_Step_Dn) begin
      w_Pattern_Next = (r_Pattern == 4'd0) ? LAST_PAT : r_Pattern - 4'd1;
    end else begin
      w_Pattern_Next = r_Pattern;
    end

    if (!i_Auto_En) begin
      w_Auto_Cnt_Next = '0;
    end else if (w_Frame_Start) begin
      w_Auto_Cnt_Next = (w_Step_Up | w_Step_Dn) ? '0 : r_Auto_Cnt + 1'b1;
    end else begin
      w_Auto_Cnt_Next = r_Auto_Cnt;
    end
  end

  // VSync delayed high in reset so an already-high VSync is not a frame start.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_VSync_d     <= 1'b1;
      r_State       <= IDLE;
      r_Pending     <= 1'b0;
      r_Frame_Start <= 1'b0;
      r_Frame_Count <= 16'd0;
      r_Pattern     <= INIT_PAT;
      r_Auto_Cnt    <= '0;
    end else begin
      r_VSync_d     <= i_VSync;
      r_State       <= w_State_Next;
      r_Pending     <= (w_State_Next != IDLE);
      r_Frame_Start <= w_Frame_Start;
      r_Frame_Count <= w_Frame_Start ? r_Frame_Count + 16'd1 : r_Frame_Count;
      r_Pattern     <= w_Pattern_Next;
      r_Auto_Cnt    <= w_Auto_Cnt_Next;
    end
  end

  assign o_Pattern     = r_Pattern;
  assign o_Pending     = r_Pending;
  assign o_Frame_Start = r_Frame_Start;
  assign o_Frame_Count = r_Frame_Count;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench: each frame driven pushes the expected pattern/count/pending,
// and a monitor pops and compares whenever the sequencer pulses o_Frame_Start.
module tb_vga_pattern_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_VSync;
  logic        i_Next;
  logic        i_Prev;
  logic        i_Auto_En;
  logic [3:0]  o_Pattern;
  logic        o_Pending;
  logic        o_Frame_Start;
  logic [15:0] o_Frame_Count;

  typedef struct {
    logic [3:0]  pat;
    logic [15:0] cnt;
    logic        pend;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_fc;
  int          n_checks = 0;
  int          n_errors = 0;

  vga_pattern_sequencer #(
    .PATTERN_COUNT(8),
    .INIT_PATTERN (0),
    .AUTO_FRAMES  (3)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_VSync      (i_VSync),
    .i_Next       (i_Next),
    .i_Prev       (i_Prev),
    .i_Auto_En    (i_Auto_En),
    .o_Pattern    (o_Pattern),
    .o_Pending    (o_Pending),
    .o_Frame_Start(o_Frame_Start),
    .o_Frame_Count(o_Frame_Count)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // One frame: VSync rises (optionally with a coincident i_Next), active rows, blanking.
  task automatic frame(input logic [3:0] pat, input logic pend, input logic co_next);
    exp_fc = exp_fc + 16'd1;
    exp_q.push_back('{pat: pat, cnt: exp_fc, pend: pend});
    i_VSync = 1'b1;
    i_Next  = co_next;
    tick();
    i_Next = 1'b0;
    repeat (5) tick();
    i_VSync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic req(input logic nxt, input logic prv);
    i_Next = nxt;
    i_Prev = prv;
    tick();
    i_Next = 1'b0;
    i_Prev = 1'b0;
    tick();
  endtask

  always @(negedge i_Clk) begin
    if (!i_Reset && o_Frame_Start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_start", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fs_pattern", {12'd0, o_Pattern}, {12'd0, e.pat});
        chk("fs_count", o_Frame_Count, e.cnt);
        chk("fs_pending", {15'd0, o_Pending}, {15'd0, e.pend});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_fc    = 16'd0;
    i_Reset   = 1'b1;
    i_VSync   = 1'b1;
    i_Next    = 1'b0;
    i_Prev    = 1'b0;
    i_Auto_En = 1'b0;
    #2;
    chk("rst_pattern", {12'd0, o_Pattern}, 16'd0);
    chk("rst_pending", {15'd0, o_Pending}, 16'd0);
    chk("rst_fs", {15'd0, o_Frame_Start}, 16'd0);
    chk("rst_fc", o_Frame_Count, 16'd0);
    tick();
    i_Reset = 1'b0;
    repeat (4) tick();
    chk("rel_high_no_fs", o_Frame_Count, 16'd0);
    i_VSync = 1'b0;
    repeat (3) tick();

    // Walk up to pattern 3.
    for (int p = 1; p <= 3; p++) begin
      req(1'b1, 1'b0);
      chk("pend_after_next", {15'd0, o_Pending}, 16'd1);
      frame(4'(p), 1'b0, 1'b0);
    end

    // Next pulse mid-frame from 3: pending holds, no early pattern change.
    req(1'b1, 1'b0);
    repeat (3) tick();
    chk("pend_hold", {15'd0, o_Pending}, 16'd1);
    chk("no_mid_frame_change", {12'd0, o_Pattern}, 16'd3);
    frame(4'd4, 1'b0, 1'b0);
    chk("pend_cleared", {15'd0, o_Pending}, 16'd0);

    for (int p = 5; p <= 7; p++) begin
      req(1'b1, 1'b0);
      frame(4'(p), 1'b0, 1'b0);
    end
    req(1'b1, 1'b0);
    frame(4'd0, 1'b0, 1'b0);
    req(1'b0, 1'b1);
    frame(4'd7, 1'b0, 1'b0);
    req(1'b1, 1'b0);
    frame(4'd0, 1'b0, 1'b0);

    // Cancellation, simultaneous requests, no queuing.
    req(1'b1, 1'b0);
    req(1'b0, 1'b1);
    chk("cancel_next", {15'd0, o_Pending}, 16'd0);
    frame(4'd0, 1'b0, 1'b0);
    req(1'b1, 1'b1);
    chk("both_idle", {15'd0, o_Pending}, 16'd0);
    frame(4'd0, 1'b0, 1'b0);
    req(1'b1, 1'b0);
    req(1'b1, 1'b1);
    chk("both_pending", {15'd0, o_Pending}, 16'd1);
    frame(4'd1, 1'b0, 1'b0);
    req(1'b1, 1'b0);
    req(1'b1, 1'b0);
    frame(4'd2, 1'b0, 1'b0);
    req(1'b0, 1'b1);
    req(1'b1, 1'b0);
    chk("cancel_prev", {15'd0, o_Pending}, 16'd0);
    frame(4'd2, 1'b0, 1'b0);

    // Next coincident with the VSync rise applies one frame later.
    frame(4'd2, 1'b1, 1'b1);
    frame(4'd3, 1'b0, 1'b0);

    // Reset while pending with VSync held high.
    exp_fc = exp_fc + 16'd1;
    exp_q.push_back('{pat: 4'd3, cnt: exp_fc, pend: 1'b0});
    i_VSync = 1'b1;
    repeat (2) tick();
    req(1'b1, 1'b0);
    chk("pend_before_rst", {15'd0, o_Pending}, 16'd1);
    i_Reset = 1'b1;
    #1;
    chk("mid_rst_pattern", {12'd0, o_Pattern}, 16'd0);
    chk("mid_rst_pending", {15'd0, o_Pending}, 16'd0);
    chk("mid_rst_fs", {15'd0, o_Frame_Start}, 16'd0);
    chk("mid_rst_fc", o_Frame_Count, 16'd0);
    tick();
    i_Reset = 1'b0;
    exp_fc  = 16'd0;
    repeat (5) tick();
    chk("post_rst_no_fs", o_Frame_Count, 16'd0);
    i_VSync = 1'b0;
    repeat (3) tick();
    frame(4'd0, 1'b0, 1'b0);

    // Auto-advance every 3 frames, with a manual prev taking priority.
    i_Auto_En = 1'b1;
    frame(4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0, 1'b0);
    frame(4'd1, 1'b0, 1'b0);
    frame(4'd1, 1'b0, 1'b0);
    frame(4'd1, 1'b0, 1'b0);
    req(1'b0, 1'b1);
    frame(4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0, 1'b0);
    frame(4'd1, 1'b0, 1'b0);
    frame(4'd1, 1'b0, 1'b0);
    frame(4'd1, 1'b0, 1'b0);
    frame(4'd2, 1'b0, 1'b0);
    i_Auto_En = 1'b0;
    frame(4'd2, 1'b0, 1'b0);
    frame(4'd2, 1'b0, 1'b0);
    frame(4'd2, 1'b0, 1'b0);

    repeat (4) tick();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
